uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- UART receive front end, directly upstream of the parity checker.
- Synchronises the serial line, finds the start bit and samples each bit mid-cell from a 16x baud enable.
- Assembles the data byte LSB-first and presents RX_DATA, the sampled parity bit and a parity_load strobe to the checker.
- Frame format is fixed: 1 start, 8 data (LSB first), 1 even-parity bit, 1 stop.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit cell; even, minimum 8.
- DATA_BITS, 8, data bits per frame; RX_DATA width.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_tick  input  1  one-clk enable at OVERSAMPLE x baud rate.
- rx_serial  input  1  raw asynchronous serial line, idle high.
- RX_DATA  output  DATA_BITS  received byte, drives the checker's RX_DATA.
- parity_bit  output  1  sampled parity bit, drives the checker's RX_in.
- parity_load  output  1  one-clk strobe; checker evaluates during this cycle.
- data_valid  output  1  one-clk pulse at end of frame.
- frame_error  output  1  stop bit sampled low; qualified by data_valid.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - RX_DATA = 0; parity_bit, parity_load, data_valid, frame_error, busy = 0.
  - The 2-FF synchroniser resets to 1 (idle) so no false start occurs after reset.
  - State resets to IDLE; tick and bit counters reset to 0.
- Synchronisation: 2-FF synchroniser on rx_serial; all logic uses the synchronised value rxs.
- State changes and counter updates occur only on clk edges where baud_tick = 1. Exception: one-clk output pulses self-clear on the next clk.
- IDLE:
  - On tick with rxs = 0: go to START, tick_cnt = 0.
- START:
  - Sample at tick_cnt = OVERSAMPLE/2-1.
  - If sample = 1: glitch; return to IDLE with no outputs.
  - If sample = 0: go to DATA, tick_cnt = 0, bit_cnt = 0.
- DATA:
  - Sample when tick_cnt = OVERSAMPLE-1, i.e. mid-cell; shift the sample into the shift register MSB so bits land LSB-first.
  - After sample number DATA_BITS: RX_DATA <= completed shift register, go to PARITY.
  - RX_DATA holds that value until the next frame's final data sample.
- PARITY:
  - Sample at tick_cnt = OVERSAMPLE-1; parity_bit <= sample.
  - On the next clk, parity_load = 1 for exactly one clk; RX_DATA and parity_bit are stable during and after the strobe.
  - Go to STOP.
- STOP:
  - Sample at tick_cnt = OVERSAMPLE-1.
  - data_valid = 1 for one clk; frame_error = ~sample, held until the next data_valid.
  - Return to IDLE.
  - A stop sampled low does not cause immediate restart: IDLE requires a tick with rxs = 0 anyway, and a break condition simply begins a new start search.
- Latency: parity_load occurs 1 clk after the parity sample tick; data_valid occurs 1 clk after the stop sample tick.
- Counters:
  - tick_cnt width is $clog2(OVERSAMPLE) and wraps to 0 on each sample.
  - bit_cnt width is $clog2(DATA_BITS+1).
- baud_tick absent: the FSM freezes; pulses never stretch.
- Reset asserted mid-frame: immediate return to IDLE and reset values; the partial byte is discarded and RX_DATA is cleared.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit value (start, data, parity, stop) is the 2-of-3 majority of rxs at tick_cnt = mid-1, mid and mid+1. mid is OVERSAMPLE/2-1 for START and OVERSAMPLE-1 for the other states.
  - The decision and all timing occur at mid+1, so every output strobe moves one baud_tick later.
- Undefined: single sample at mid, as described in Behaviour.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - default constants UART_OVERSAMPLE = 16 and UART_DATA_BITS = 8.
- One natural sub-module: uart_rx_sync, the 2-FF synchroniser with reset-to-1. It also houses the 3-sample history registers when UART_RX_MAJORITY_EN is defined.

Test Plan:
- Frame 0xA5 with parity 0, stop 1, 16 ticks per bit:
  - RX_DATA = 8'hA5 and parity_bit = 0 at parity_load.
  - The checker reports no error; data_valid pulses once and frame_error = 0.
- Frame 0x01 with parity 0 (wrong for even parity): parity_bit = 0 and RX_DATA = 8'h01 at parity_load, so the downstream checker flags parity_error = 1.
- rx_serial low for 4 ticks then high: START returns to IDLE; no parity_load or data_valid; busy drops.
- Frame 0x3C with stop bit 0: data_valid pulses with frame_error = 1. A following good frame 0x55 gives frame_error = 0.
- rst asserted during data bit 4 of a frame: all outputs = 0 immediately. The next clean frame 0x7E is received correctly.
- With UART_RX_MAJORITY_EN defined, a 1-tick inverted glitch at the centre of each data bit of frame 0xC3 still yields RX_DATA = 8'hC3. Without the macro the same stimulus corrupts the byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive front end.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line, reset to idle-high.
// With UART_RX_MAJORITY_EN it also keeps a tick-spaced history and votes 2-of-3.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef UART_RX_MAJORITY_EN
    input  logic i_tick,
`endif
    input  logic i_rx,
    output logic o_rxs,
    output logic o_bit
);

    logic r_meta;
    logic r_sync;

    // Metastability filter on the raw line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
        end
    end

    assign o_rxs = r_sync;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // History of the synchronised line as seen on the two previous ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (i_tick) begin
            r_hist <= {r_hist[0], r_sync};
        end else begin
            r_hist <= r_hist;
        end
    end

    assign o_bit = maj3(r_hist[1], r_hist[0], r_sync);
`else
    assign o_bit = r_sync;
`endif

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: start detect, mid-cell sampling, LSB-first assembly, parity/stop capture.
// Build option UART_RX_MAJORITY_EN selects 2-of-3 voting, deciding one tick later.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 parity_bit,
    output logic                 parity_load,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_PT_I = OVERSAMPLE / 2;
`else
    localparam int START_PT_I = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [TW-1:0] START_PT = TW'(START_PT_I);
    localparam logic [TW-1:0] MID_PT   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic w_rxs;
    logic w_bit;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
`ifdef UART_RX_MAJORITY_EN
        .i_tick (baud_tick),
`endif
        .i_rx   (rx_serial),
        .o_rxs  (w_rxs),
        .o_bit  (w_bit)
    );

    uart_state_e          r_state;
    uart_state_e          w_next_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [TW-1:0]        w_next_tick;
    logic [BW-1:0]        r_bit_cnt;
    logic [BW-1:0]        w_next_bit;
    logic                 w_shift_en;
    logic                 w_load_data;
    logic                 w_parity_smp;
    logic                 w_stop_smp;

    logic [DATA_BITS-2:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_parity_bit;
    logic                 r_pload_pend;
    logic                 r_parity_load;
    logic                 r_stop_pend;
    logic                 r_stop_bit;
    logic                 r_data_valid;
    logic                 r_frame_error;
    logic                 r_busy;

    // State, tick and bit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_tick_cnt <= w_next_tick;
            r_bit_cnt  <= w_next_bit;
        end
    end

    // Next-state and sample strobes; nothing advances without a baud tick.
    always_comb begin
        w_next_state = r_state;
        w_next_tick  = r_tick_cnt;
        w_next_bit   = r_bit_cnt;
        w_shift_en   = 1'b0;
        w_load_data  = 1'b0;
        w_parity_smp = 1'b0;
        w_stop_smp   = 1'b0;
        if (baud_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        w_next_state = START;
                        w_next_tick  = '0;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                START: begin
                    if (r_tick_cnt == START_PT) begin
                        w_next_tick  = '0;
                        w_next_bit   = '0;
                        w_next_state = w_bit ? IDLE : DATA;
                    end else begin
                        w_next_tick = r_tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_tick_cnt == MID_PT) begin
                        w_next_tick = '0;
                        w_shift_en  = 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_load_data  = 1'b1;
                            w_next_bit   = '0;
                            w_next_state = PARITY;
                        end else begin
                            w_next_bit = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_next_tick = r_tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (r_tick_cnt == MID_PT) begin
                        w_next_tick  = '0;
                        w_parity_smp = 1'b1;
                        w_next_state = STOP;
                    end else begin
                        w_next_tick = r_tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_tick_cnt == MID_PT) begin
                        w_next_tick  = '0;
                        w_stop_smp   = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_next_tick = r_tick_cnt + 1'b1;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_next_tick  = '0;
                    w_next_bit   = '0;
                end
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // Datapath and output strobes; strobes trail their sample tick by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_parity_bit  <= 1'b0;
            r_pload_pend  <= 1'b0;
            r_parity_load <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_stop_bit    <= 1'b0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {w_bit, r_shift[DATA_BITS-2:1]};
            end
            if (w_load_data) begin
                r_rx_data <= {w_bit, r_shift};
            end
            if (w_parity_smp) begin
                r_parity_bit <= w_bit;
            end
            if (w_stop_smp) begin
                r_stop_bit <= w_bit;
            end
            if (r_stop_pend) begin
                r_frame_error <= ~r_stop_bit;
            end
            r_pload_pend  <= w_parity_smp;
            r_parity_load <= r_pload_pend;
            r_stop_pend   <= w_stop_smp;
            r_data_valid  <= r_stop_pend;
            r_busy        <= (w_next_state != IDLE);
        end
    end

    assign RX_DATA     = r_rx_data;
    assign parity_bit  = r_parity_bit;
    assign parity_load = r_parity_load;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: serial frames driven tick-by-tick, strobes captured by a monitor.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       rx_serial;
    logic [7:0] RX_DATA;
    logic       parity_bit;
    logic       parity_load;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int   n_checks = 0;
    int   n_err    = 0;
    logic tick_en  = 1'b1;

    int         pl_cnt = 0;
    int         dv_cnt = 0;
    int         pl_wide = 0;
    int         dv_wide = 0;
    logic [7:0] pl_data = 8'h00;
    logic       pl_par  = 1'b0;
    logic [7:0] dv_data = 8'h00;
    logic       dv_fe   = 1'b0;
    logic       prev_pl = 1'b0;
    logic       prev_dv = 1'b0;

    uart_rx_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .rx_serial   (rx_serial),
        .RX_DATA     (RX_DATA),
        .parity_bit  (parity_bit),
        .parity_load (parity_load),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Baud tick on every other clock, held low while ticks are disabled.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            baud_tick = tick_en ? ~baud_tick : 1'b0;
        end
    end

    // Strobe monitor: records what the downstream checker would see.
    initial begin
        forever begin
            @(negedge clk);
            if (parity_load) begin
                pl_cnt  = pl_cnt + 1;
                pl_data = RX_DATA;
                pl_par  = parity_bit;
                if (prev_pl) pl_wide = pl_wide + 1;
            end
            if (data_valid) begin
                dv_cnt  = dv_cnt + 1;
                dv_data = RX_DATA;
                dv_fe   = frame_error;
                if (prev_dv) dv_wide = dv_wide + 1;
            end
            prev_pl = parity_load;
            prev_dv = data_valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (baud_tick) k = k + 1;
        end
    endtask

    task automatic send_bit(input logic b);
        #1 rx_serial = b;
        wait_ticks(16);
    endtask

    task automatic send_glitch_bit(input logic b);
        #1 rx_serial = b;
        wait_ticks(8);
        #1 rx_serial = ~b;
        wait_ticks(1);
        #1 rx_serial = b;
        wait_ticks(7);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic freeze, input logic glitch);
        wait_ticks(1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (freeze && i == 3) begin
                tick_en = 1'b0;
                repeat (40) @(posedge clk);
                #1 chk("freeze_busy", {31'd0, busy}, 32'd1);
                tick_en = 1'b1;
            end
            if (glitch) send_glitch_bit(d[i]);
            else        send_bit(d[i]);
        end
        send_bit(p);
        send_bit(s);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
    endtask

    task automatic frame_check(input string tag, input int pl0, input int dv0,
                               input logic [7:0] ed, input logic ep, input logic efe);
        chk({tag, "_pl_cnt"}, pl_cnt - pl0, 32'd1);
        chk({tag, "_pl_data"}, {24'd0, pl_data}, {24'd0, ed});
        chk({tag, "_pl_par"}, {31'd0, pl_par}, {31'd0, ep});
        chk({tag, "_chk_err"}, {31'd0, ^{pl_data, pl_par}}, {31'd0, ^{ed, ep}});
        chk({tag, "_dv_cnt"}, dv_cnt - dv0, 32'd1);
        chk({tag, "_dv_data"}, {24'd0, dv_data}, {24'd0, ed});
        chk({tag, "_dv_fe"}, {31'd0, dv_fe}, {31'd0, efe});
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pl0;
        int dv0;
        logic [7:0] exp_c3;

        rst       = 1'b1;
        rx_serial = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, RX_DATA}, 32'd0);
        chk("rst_par", {31'd0, parity_bit}, 32'd0);
        chk("rst_pl", {31'd0, parity_load}, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_error}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_ticks(20);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        pl0 = pl_cnt; dv0 = dv_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        frame_check("a5", pl0, dv0, 8'hA5, 1'b0, 1'b0);

        pl0 = pl_cnt; dv0 = dv_cnt;
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        frame_check("01", pl0, dv0, 8'h01, 1'b0, 1'b0);
        chk("01_parity_error", {31'd0, ^{pl_data, pl_par}}, 32'd1);

        pl0 = pl_cnt; dv0 = dv_cnt;
        wait_ticks(1);
        #1 rx_serial = 1'b0;
        wait_ticks(4);
        #1 rx_serial = 1'b1;
        wait_ticks(3);
        #1 chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
        wait_ticks(20);
        #1 chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
        chk("glitch_no_pl", pl_cnt - pl0, 32'd0);
        chk("glitch_no_dv", dv_cnt - dv0, 32'd0);

        pl0 = pl_cnt; dv0 = dv_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        frame_check("3c", pl0, dv0, 8'h3C, 1'b0, 1'b1);
        chk("3c_fe_held", {31'd0, frame_error}, 32'd1);

        pl0 = pl_cnt; dv0 = dv_cnt;
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        frame_check("55", pl0, dv0, 8'h55, 1'b0, 1'b0);

        pl0 = pl_cnt; dv0 = dv_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        frame_check("07", pl0, dv0, 8'h07, 1'b1, 1'b1);

        wait_ticks(1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #1 rx_serial = 1'b1;
        wait_ticks(8);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_data", {24'd0, RX_DATA}, 32'd0);
        chk("mid_rst_par", {31'd0, parity_bit}, 32'd0);
        chk("mid_rst_fe", {31'd0, frame_error}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_pl", {31'd0, parity_load}, 32'd0);
        chk("mid_rst_dv", {31'd0, data_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_ticks(32);

        pl0 = pl_cnt; dv0 = dv_cnt;
        send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
        frame_check("7e", pl0, dv0, 8'h7E, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
        exp_c3 = 8'hC3;
`else
        exp_c3 = 8'h3C;
`endif
        pl0 = pl_cnt; dv0 = dv_cnt;
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
        frame_check("c3_glitch", pl0, dv0, exp_c3, 1'b0, 1'b0);

        chk("pl_width", pl_wide, 32'd0);
        chk("dv_width", dv_wide, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
